// File: rtl/vend_ctrl_param.sv
// Vending controller with a two-denomination credit balance and a runtime price table.
// Change is paid out greedily, one coin per cycle. Cancel refunds the whole balance.
module vend_ctrl_param #(
    parameter int unsigned LO_VAL     = 5,
    parameter int unsigned HI_VAL     = 10,
    parameter int unsigned NUM_ITEMS  = 4,
    parameter int unsigned IDX_W      = 2,
    parameter int unsigned CREDIT_W   = 8,
    parameter int unsigned MAX_CREDIT = 200
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            coin_lo_i,
    input  logic                            coin_hi_i,
    input  logic                            sel_valid_i,
    input  logic [IDX_W-1:0]                sel_idx_i,
    input  logic                            cancel_i,
    input  logic [NUM_ITEMS*CREDIT_W-1:0]   prices_i,
    output logic [CREDIT_W-1:0]             credit_o,
    output logic                            busy_o,
    output logic                            vend_o,
    output logic [IDX_W-1:0]                vend_idx_o,
    output logic                            coin_out_lo_o,
    output logic                            coin_out_hi_o,
    output logic                            coin_rej_o,
    output logic                            err_funds_o,
    output logic                            err_idx_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        CHANGE = 2'd2
    } state_t;

    localparam logic [CREDIT_W:0] LO_W  = (CREDIT_W+1)'(LO_VAL);
    localparam logic [CREDIT_W:0] HI_W  = (CREDIT_W+1)'(HI_VAL);
    localparam logic [CREDIT_W:0] MAX_W = (CREDIT_W+1)'(MAX_CREDIT);

    state_t              state;
    logic [CREDIT_W-1:0] credit;
    logic [CREDIT_W-1:0] price_q;
    logic [IDX_W-1:0]    idx_q;

    logic [CREDIT_W:0]   coin_sum;
    logic                coin_any;
    logic                coin_ok;
    logic [CREDIT_W-1:0] credit_new;
    logic [CREDIT_W-1:0] sel_price;
    logic                sel_idx_ok;
    logic [CREDIT_W:0]   price_diff;
    logic                funds_ok;

    assign credit_o = credit;

    always_comb begin
        coin_sum   = {1'b0, credit} + (coin_lo_i ? LO_W : '0) + (coin_hi_i ? HI_W : '0);
        coin_any   = coin_lo_i | coin_hi_i;
        coin_ok    = (coin_sum <= MAX_W);
        credit_new = coin_ok ? coin_sum[CREDIT_W-1:0] : credit;
        sel_idx_ok = (32'(sel_idx_i) < NUM_ITEMS);
        sel_price  = '0;
        for (int unsigned k = 0; k < NUM_ITEMS; k++) begin
            if (32'(sel_idx_i) == k)
                sel_price = prices_i[k*CREDIT_W +: CREDIT_W];
        end
        // Extra borrow bit: credit < price shows up as a set MSB instead of wrapping.
        price_diff = {1'b0, credit} - {1'b0, price_q};
        funds_ok   = ~price_diff[CREDIT_W];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            credit        <= '0;
            price_q       <= '0;
            idx_q         <= '0;
            busy_o        <= 1'b0;
            vend_o        <= 1'b0;
            vend_idx_o    <= '0;
            coin_out_lo_o <= 1'b0;
            coin_out_hi_o <= 1'b0;
            coin_rej_o    <= 1'b0;
            err_funds_o   <= 1'b0;
            err_idx_o     <= 1'b0;
        end else begin
            vend_o        <= 1'b0;
            vend_idx_o    <= '0;
            coin_out_lo_o <= 1'b0;
            coin_out_hi_o <= 1'b0;
            coin_rej_o    <= 1'b0;
            err_funds_o   <= 1'b0;
            err_idx_o     <= 1'b0;

            case (state)
                IDLE: begin
                    if (coin_any) begin
                        if (coin_ok) credit <= coin_sum[CREDIT_W-1:0];
                        else         coin_rej_o <= 1'b1;
                    end
                    // An asserted cancel always masks a selection, even when it is a no-op.
                    if (cancel_i) begin
                        if (credit_new != '0) begin
                            state  <= CHANGE;
                            busy_o <= 1'b1;
                        end
                    end else if (sel_valid_i) begin
                        if (!sel_idx_ok) begin
                            err_idx_o <= 1'b1;
                        end else begin
                            idx_q   <= sel_idx_i;
                            price_q <= sel_price;
                            state   <= CHECK;
                            busy_o  <= 1'b1;
                        end
                    end
                end

                CHECK: begin
                    coin_rej_o <= coin_any;
                    if (funds_ok) begin
                        credit     <= price_diff[CREDIT_W-1:0];
                        vend_o     <= 1'b1;
                        vend_idx_o <= idx_q;
                        state      <= CHANGE;
                    end else begin
                        err_funds_o <= 1'b1;
                        state       <= IDLE;
                        busy_o      <= 1'b0;
                    end
                end

                CHANGE: begin
                    coin_rej_o <= coin_any;
                    if ({1'b0, credit} >= HI_W) begin
                        coin_out_hi_o <= 1'b1;
                        credit        <= credit - HI_W[CREDIT_W-1:0];
                    end else if ({1'b0, credit} >= LO_W) begin
                        coin_out_lo_o <= 1'b1;
                        credit        <= credit - LO_W[CREDIT_W-1:0];
                    end else begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Directed bench for vend_ctrl_param: per-cycle vector table plus hand-written sequences
// for the credit ceiling, zero price, and asynchronous reset during change payout.
module tb_vend_ctrl_param;

    localparam int unsigned NI = 3;
    localparam int unsigned IW = 2;
    localparam int unsigned CW = 8;

    logic              clk;
    logic              reset_n;
    logic              coin_lo, coin_hi, sel_valid, cancel;
    logic [IW-1:0]     sel_idx;
    logic [NI*CW-1:0]  prices;
    logic [CW-1:0]     credit;
    logic              busy, vend, out_lo, out_hi, rej, err_funds, err_idx;
    logic [IW-1:0]     vend_idx;

    vend_ctrl_param #(
        .LO_VAL(5), .HI_VAL(10), .NUM_ITEMS(NI), .IDX_W(IW), .CREDIT_W(CW), .MAX_CREDIT(200)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .coin_lo_i(coin_lo), .coin_hi_i(coin_hi),
        .sel_valid_i(sel_valid), .sel_idx_i(sel_idx), .cancel_i(cancel),
        .prices_i(prices),
        .credit_o(credit), .busy_o(busy), .vend_o(vend), .vend_idx_o(vend_idx),
        .coin_out_lo_o(out_lo), .coin_out_hi_o(out_hi), .coin_rej_o(rej),
        .err_funds_o(err_funds), .err_idx_o(err_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] cr;
        logic          busy;
        logic          vend;
        logic [IW-1:0] vidx;
        logic          olo;
        logic          ohi;
        logic          rej;
        logic          ef;
        logic          ei;
    } out_t;

    typedef struct {
        logic          lo, hi, sel, can;
        logic [IW-1:0] idx;
        out_t          exp;
        string         name;
    } vec_t;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;
    vec_t vecs[$];

    function automatic out_t o(input int cr, input logic b, input logic vd, input int vi,
                               input logic ol, input logic oh, input logic rj,
                               input logic ef, input logic ei);
        out_t r;
        r.cr = CW'(cr); r.busy = b; r.vend = vd; r.vidx = IW'(vi);
        r.olo = ol; r.ohi = oh; r.rej = rj; r.ef = ef; r.ei = ei;
        return r;
    endfunction

    function automatic vec_t v(input logic lo, input logic hi, input logic sel, input int idx,
                               input logic can, input out_t exp, input string name);
        vec_t r;
        r.lo = lo; r.hi = hi; r.sel = sel; r.idx = IW'(idx); r.can = can;
        r.exp = exp; r.name = name;
        return r;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
    task automatic cyc(input logic lo, input logic hi, input logic sel, input logic [IW-1:0] idx,
                       input logic can);
        @(negedge clk);
        coin_lo = lo; coin_hi = hi; sel_valid = sel; sel_idx = idx; cancel = can;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input out_t exp);
        out_t act;
        act = {credit, busy, vend, vend_idx, out_lo, out_hi, rej, err_funds, err_idx};
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got cr=%0d busy=%b vend=%b vidx=%0d lo=%b hi=%b rej=%b ef=%b ei=%b, expected cr=%0d busy=%b vend=%b vidx=%0d lo=%b hi=%b rej=%b ef=%b ei=%b",
                     name, act.cr, act.busy, act.vend, act.vidx, act.olo, act.ohi, act.rej, act.ef, act.ei,
                     exp.cr, exp.busy, exp.vend, exp.vidx, exp.olo, exp.ohi, exp.rej, exp.ef, exp.ei);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        coin_lo = 0; coin_hi = 0; sel_valid = 0; sel_idx = '0; cancel = 0;
        prices = {8'd40, 8'd15, 8'd35};

        // Test 1: hi + lo, item 1 at 15, exact payment
        vecs.push_back(v(0,1,0,0,0, o(10,0,0,0,0,0,0,0,0), "t1 hi coin"));
        vecs.push_back(v(1,0,0,0,0, o(15,0,0,0,0,0,0,0,0), "t1 lo coin"));
        vecs.push_back(v(0,0,1,1,0, o(15,1,0,0,0,0,0,0,0), "t1 select"));
        vecs.push_back(v(0,0,0,0,0, o( 0,1,1,1,0,0,0,0,0), "t1 vend"));
        vecs.push_back(v(0,0,0,0,0, o( 0,0,0,0,0,0,0,0,0), "t1 no change"));
        // Test 2: 50 credit, item 0 at 35 -> one hi and one lo coin; select in CHANGE ignored
        for (int k = 1; k <= 5; k++)
            vecs.push_back(v(0,1,0,0,0, o(10*k,0,0,0,0,0,0,0,0), "t2 hi coin"));
        vecs.push_back(v(0,0,1,0,0, o(50,1,0,0,0,0,0,0,0), "t2 select"));
        vecs.push_back(v(0,0,0,0,0, o(15,1,1,0,0,0,0,0,0), "t2 vend"));
        vecs.push_back(v(0,0,1,1,0, o( 5,1,0,0,0,1,0,0,0), "t2 change hi"));
        vecs.push_back(v(0,0,0,0,0, o( 0,1,0,0,1,0,0,0,0), "t2 change lo"));
        vecs.push_back(v(0,0,0,0,0, o( 0,0,0,0,0,0,0,0,0), "t2 idle"));
        vecs.push_back(v(0,0,0,0,0, o( 0,0,0,0,0,0,0,0,0), "t2 sel not queued"));
        // Test 3: insufficient funds (coin during CHECK bounced), then cancel
        vecs.push_back(v(0,1,0,0,0, o(10,0,0,0,0,0,0,0,0), "t3 hi coin"));
        vecs.push_back(v(0,0,1,2,0, o(10,1,0,0,0,0,0,0,0), "t3 select 40"));
        vecs.push_back(v(1,0,0,0,0, o(10,0,0,0,0,0,1,1,0), "t3 err funds"));
        vecs.push_back(v(0,0,0,0,1, o(10,1,0,0,0,0,0,0,0), "t3 cancel"));
        vecs.push_back(v(0,0,0,0,0, o( 0,1,0,0,0,1,0,0,0), "t3 refund hi"));
        vecs.push_back(v(0,0,0,0,0, o( 0,0,0,0,0,0,0,0,0), "t3 idle"));
        // Test 5: cancel beats select; bad index; cancel at zero credit ignored
        vecs.push_back(v(0,1,0,0,0, o(10,0,0,0,0,0,0,0,0), "t5 hi coin a"));
        vecs.push_back(v(0,1,0,0,0, o(20,0,0,0,0,0,0,0,0), "t5 hi coin b"));
        vecs.push_back(v(0,0,1,0,1, o(20,1,0,0,0,0,0,0,0), "t5 cancel+sel"));
        vecs.push_back(v(0,0,0,0,0, o(10,1,0,0,0,1,0,0,0), "t5 refund hi a"));
        vecs.push_back(v(0,0,0,0,0, o( 0,1,0,0,0,1,0,0,0), "t5 refund hi b"));
        vecs.push_back(v(0,0,0,0,0, o( 0,0,0,0,0,0,0,0,0), "t5 idle"));
        vecs.push_back(v(0,0,1,3,0, o( 0,0,0,0,0,0,0,0,1), "t5 err idx"));
        vecs.push_back(v(0,0,0,0,1, o( 0,0,0,0,0,0,0,0,0), "t5 cancel at zero"));
        // Coin on the select cycle counts toward the price check
        for (int k = 1; k <= 3; k++)
            vecs.push_back(v(0,1,0,0,0, o(10*k,0,0,0,0,0,0,0,0), "sc hi coin"));
        vecs.push_back(v(1,0,1,0,0, o(35,1,0,0,0,0,0,0,0), "sc lo+select"));
        vecs.push_back(v(0,0,0,0,0, o( 0,1,1,0,0,0,0,0,0), "sc vend"));
        vecs.push_back(v(0,0,0,0,0, o( 0,0,0,0,0,0,0,0,0), "sc idle"));

        repeat (2) @(posedge clk);
        #1;
        chk("reset state", o(0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            cyc(vecs[i].lo, vecs[i].hi, vecs[i].sel, vecs[i].idx, vecs[i].can);
            chk(vecs[i].name, vecs[i].exp);
        end

        // Test 4: credit ceiling, and coins bounced while paying out change
        for (int k = 1; k <= 13; k++) begin
            cyc(1, 1, 0, '0, 0);
            chk("t4 both coins", o(15*k,0,0,0,0,0,0,0,0));
        end
        cyc(0, 1, 0, '0, 0); chk("t4 hi over max", o(195,0,0,0,0,0,1,0,0));
        cyc(1, 0, 0, '0, 0); chk("t4 lo to max",   o(200,0,0,0,0,0,0,0,0));
        cyc(1, 0, 0, '0, 0); chk("t4 lo over max", o(200,0,0,0,0,0,1,0,0));
        cyc(0, 0, 0, '0, 1); chk("t4 cancel",      o(200,1,0,0,0,0,0,0,0));
        cyc(0, 1, 0, '0, 0); chk("t4 coin in change", o(190,1,0,0,0,1,1,0,0));
        for (int k = 1; k <= 19; k++) begin
            cyc(0, 0, 0, '0, 0);
            chk("t4 refund hi", o(190-10*k,1,0,0,0,1,0,0,0));
        end
        cyc(0, 0, 0, '0, 0); chk("t4 idle", o(0,0,0,0,0,0,0,0,0));

        // Zero price vends with no credit; price change after select has no effect
        prices[7:0] = 8'd0;
        cyc(0, 0, 1, 2'd0, 0); chk("p0 select", o(0,1,0,0,0,0,0,0,0));
        prices[7:0] = 8'd200;
        cyc(0, 0, 0, '0, 0);   chk("p0 vend",   o(0,1,1,0,0,0,0,0,0));
        cyc(0, 0, 0, '0, 0);   chk("p0 idle",   o(0,0,0,0,0,0,0,0,0));

        // Test 6: asynchronous reset while in CHANGE with credit 30
        for (int k = 1; k <= 3; k++) begin
            cyc(0, 1, 0, '0, 0);
            chk("t6 hi coin", o(10*k,0,0,0,0,0,0,0,0));
        end
        cyc(0, 0, 0, '0, 1); chk("t6 cancel", o(30,1,0,0,0,0,0,0,0));
        cyc(0, 0, 0, '0, 0); chk("t6 refund hi", o(20,1,0,0,0,1,0,0,0));
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("t6 async reset", o(0,0,0,0,0,0,0,0,0));
        @(posedge clk);
        #1;
        chk("t6 held reset", o(0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, '0, 0);
            chk("t6 no pulses", o(0,0,0,0,0,0,0,0,0));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
